mul_share_arbiter: RTL and testbench
====================================

Name: mul_share_arbiter

Overview:
- Shares one 2-stage pipelined signed/unsigned N-bit multiplier between NUM_REQ requesters.
- Arbitration is round-robin.
- Each result returns on a single output channel, tagged with the requester index.
- Sits between several datapath clients, such as filter taps or accumulators, and a single multiplier resource.
- Uses valid/ready on both the request side and the result side.

Parameters:
- n, 8, operand width; result width is 2*n.
- NUM_REQ, 4, number of requesters (2..16).
- ID_W, $clog2(NUM_REQ), width of the requester tag.

Ports:
- Clocking and reset (already decided): one clock `clk`; asynchronous, active-low reset `rst_n`.
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester accept; at most one bit high.
- req_a  in  NUM_REQ*n  operand a; requester i occupies bits [i*n +: n].
- req_b  in  NUM_REQ*n  operand b; same packing as req_a.
- req_signed  in  NUM_REQ  per-requester mode: 1 = two's-complement, 0 = unsigned.
- res_valid  out  1  result valid.
- res_ready  in  1  result consumer ready.
- res  out  2*n  product.
- res_id  out  ID_W  index of the requester that issued this result.

Behaviour:
- Reset values:
  - res_valid=0, res=0, res_id=0, req_ready=0.
  - Internal stage valids = 0.
  - Round-robin pointer last_grant = NUM_REQ-1, so requester 0 has first priority after reset.
- Reset mid-operation discards all in-flight operations.
  - No result is produced for them.
  - Requesters must re-issue.
- Pipeline structure:
  - S1: registered operands, mode and id.
  - S2: registered product and id. S2 drives the res/res_id/res_valid outputs directly.
- Pipeline control:
  - advance = !s2_valid | res_ready.
  - s1_free = !s1_valid | advance.
- Grant (combinational):
  - The first i with req_valid[i]=1, scanning (last_grant+1) mod NUM_REQ upward with wrap.
  - req_ready[i] = (i==grant) & req_valid[i] & s1_free.
  - req_ready never depends combinationally on res_ready except through advance.
- Handshake:
  - A request transfers when req_valid[i] & req_ready[i].
  - On transfer: last_grant <= i.
  - The pointer does not move when nothing transfers.
  - A requester must hold its operands and valid stable until accepted.
- Latency and throughput:
  - Accept at edge t → res_valid=1 in the cycle after edge t+1, i.e. 2-cycle latency, when res_ready stays high.
  - Full throughput is 1 op/cycle.
- Backpressure:
  - While res_valid=1 and res_ready=0, S2 holds and S1 holds.
  - req_ready drops only if S1 is occupied.
  - The pipeline therefore holds 2 outstanding ops, with no loss and no duplication.
  - When the pipeline drains, S1 moves into S2 in the same cycle that S2's result is consumed.
- Arithmetic, computed in the S1→S2 transfer:
  - signed=1: res = sign-extended a × sign-extended b, full 2n-bit two's-complement product.
    - Corner case: (-2^(n-1)) × (-2^(n-1)) = +2^(2n-2), no overflow.
  - signed=0: zero-extended product.
  - Mode is captured per operation; mixed modes back-to-back are legal.
- Fairness: with k requesters continuously valid, each is granted exactly once every k accepted transfers.
- Simultaneous events:
  - An accept into S1 and a drain of S2 in the same cycle are both honoured.
  - A requester that deasserts valid before acceptance simply loses its slot; the pointer is unchanged.
- Single requester: always granted on back-to-back cycles.

Decomposition:
- Package mul_share_pkg:
  - localparam default widths;
  - function rr_pick(valid vector, last_grant) returning the grant index and a found bit;
  - typedef struct for the S1 payload {a, b, signed_mul, id}.
- One sub-module: mul_share_rr_arbiter.
  - Inputs: req_valid, accept-enable.
  - Outputs: grant index and one-hot grant.
  - Owns last_grant and its update on transfer.
- Multiplier and pipeline registers stay in the top level.

Test Plan:
1. Reset then single op: req0 a=8'hFF, b=8'h02, signed=1, res_ready=1 → accepted cycle 0; res=16'hFFFE, res_id=0, res_valid in cycle 2. Same operands with signed=0 → res=16'h01FE.
2. Corner: a=b=8'h80, signed=1 → res=16'h4000; unsigned → res=16'h4000. Then a=8'h80, b=8'h7F, signed=1 → 16'hC080; unsigned → 16'h3F80.
3. All 4 requesters valid continuously, res_ready=1 → grant order 0,1,2,3,0,1…; res_id sequence matches, 1 result/cycle after 2-cycle fill.
4. Backpressure: 3 back-to-back requests, res_ready=0 from cycle 2 for 5 cycles → exactly 2 ops held; req_ready low until res_ready rises; results emerge in order with no gaps lost or repeats.
5. Requester 2 drops valid before grant while 1 and 3 are valid → pointer skips 2; order 1,3,1,3; no result with res_id=2.
6. Assert rst_n low asynchronously with 2 ops in flight → res_valid=0 immediately; after release no stale result appears; next grant goes to requester 0.

Source files
------------

// File: rtl/mul_share_pkg.sv
// Shared widths, payload type and round-robin pick helper for the multiplier share block.
// Latency: none (types and a combinational function only).
// Backpressure: not applicable.
package mul_share_pkg;

  localparam int N_DEF       = 8;
  localparam int NUM_REQ_DEF = 4;
  localparam int ID_W_DEF    = $clog2(NUM_REQ_DEF);

  // Upper bounds the pick helper is written for (NUM_REQ up to 16).
  localparam int MAX_REQ  = 16;
  localparam int MAX_ID_W = 4;

  typedef struct packed {
    logic                found;
    logic [MAX_ID_W-1:0] idx;
  } rr_pick_t;

  // Stage-1 payload. Field widths follow the package defaults; the top's
  // operand width and requester count are expected to match them.
  typedef struct packed {
    logic [N_DEF-1:0]    a;
    logic [N_DEF-1:0]    b;
    logic                signed_mul;
    logic [ID_W_DEF-1:0] id;
  } s1_payload_t;

  // First valid index scanning upward from last+1, wrapping at num_req.
  function automatic rr_pick_t rr_pick(input logic [MAX_REQ-1:0]  valid,
                                       input logic [MAX_ID_W-1:0] last,
                                       input int unsigned         num_req);
    localparam int CW = MAX_ID_W + 1;
    rr_pick_t       r;
    logic [CW-1:0]  cand;
    r = '0;
    for (int unsigned k = 1; k <= MAX_REQ; k++) begin
      cand = {1'b0, last} + CW'(k);
      if (cand >= CW'(num_req)) begin
        cand = cand - CW'(num_req);
      end
      if ((k <= num_req) && !r.found && valid[cand[MAX_ID_W-1:0]]) begin
        r.found = 1'b1;
        r.idx   = cand[MAX_ID_W-1:0];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/mul_share_rr_arbiter.sv
// Round-robin grant over the requesters; owns the last-grant pointer.
// Latency: grant is combinational; the pointer updates on the edge that accepts.
// Backpressure: accept_en low forces an all-zero grant and freezes the pointer.
module mul_share_rr_arbiter
  import mul_share_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic               accept_en,
  output logic [ID_W-1:0]    grant_idx,
  output logic [NUM_REQ-1:0] grant_oh
);

  logic [ID_W-1:0] last_grant;
  rr_pick_t        pick;

  // Pick the next valid requester after the last one served; gate by accept_en.
  always_comb begin
    pick      = rr_pick(MAX_REQ'(req_valid), MAX_ID_W'(last_grant), NUM_REQ);
    grant_idx = pick.idx[ID_W-1:0];
    grant_oh  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      grant_oh[i] = accept_en & pick.found & req_valid[i] & (pick.idx == MAX_ID_W'(i));
    end
  end

  // Move the pointer only when a request actually transfers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= ID_W'(NUM_REQ - 1);
    end else if (|grant_oh) begin
      last_grant <= grant_idx;
    end
  end

endmodule

// File: rtl/mul_share_arbiter.sv
// Shares one 2-stage signed/unsigned multiplier among NUM_REQ requesters, results tagged by id.
// Latency: 2 cycles from accept edge to res_valid; 1 op/cycle sustained.
// Backpressure: res_ready low stalls S2 then S1; req_ready drops only while S1 cannot move.
module mul_share_arbiter
  import mul_share_pkg::*;
#(
  parameter int n       = N_DEF,
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic [NUM_REQ*n-1:0] req_a,
  input  logic [NUM_REQ*n-1:0] req_b,
  input  logic [NUM_REQ-1:0]   req_signed,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [2*n-1:0]       res,
  output logic [ID_W-1:0]      res_id
);

  logic            s1_valid;
  s1_payload_t     s1;
  s1_payload_t     s1_next;
  logic            s2_valid;
  logic [2*n-1:0]  s2_res;
  logic [ID_W-1:0] s2_id;

  logic            advance;
  logic            s1_free;
  logic            accept_en;
  logic            take;
  logic [ID_W-1:0] grant_idx;
  logic [2*n-1:0]  a_ext;
  logic [2*n-1:0]  b_ext;
  logic [2*n-1:0]  prod;

  // Stage handshake; reset also holds off grants so req_ready reads 0 in reset.
  always_comb begin
    advance   = !s2_valid | res_ready;
    s1_free   = !s1_valid | advance;
    accept_en = s1_free & rst_n;
    take      = |req_ready;
  end

  mul_share_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .accept_en (accept_en),
    .grant_idx (grant_idx),
    .grant_oh  (req_ready)
  );

  // Steer the granted requester's operands and mode into the S1 payload.
  always_comb begin
    s1_next            = '0;
    s1_next.a          = req_a[grant_idx*n +: n];
    s1_next.b          = req_b[grant_idx*n +: n];
    s1_next.signed_mul = req_signed[grant_idx];
    s1_next.id         = grant_idx;
  end

  // Extend operands to the full product width (sign or zero) so the low 2n bits are exact.
  always_comb begin
    a_ext = {{n{s1.signed_mul & s1.a[n-1]}}, s1.a};
    b_ext = {{n{s1.signed_mul & s1.b[n-1]}}, s1.b};
    prod  = a_ext * b_ext;
  end

  // S1: capture a newly accepted request whenever the stage can give up its contents.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1       <= '0;
    end else if (s1_free) begin
      s1_valid <= take;
      if (take) begin
        s1 <= s1_next;
      end
    end
  end

  // S2: register the product; holds while the consumer is stalling.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2_res   <= '0;
      s2_id    <= '0;
    end else if (advance) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_res <= prod;
        s2_id  <= s1.id;
      end
    end
  end

  assign res_valid = s2_valid;
  assign res       = s2_res;
  assign res_id    = s2_id;

endmodule

// File: tb/tb_mul_share_arbiter.sv
// Self-checking bench for mul_share_arbiter: table vectors, directed corner sequences, random traffic.
// Latency: checks the 2-cycle accept-to-result timing directly.
// Backpressure: drives res_ready low/random and checks req_ready against an occupancy model.
module tb_mul_share_arbiter;

  localparam int N = 8;
  localparam int R = 4;

  logic           clk;
  logic           rst_n;
  logic [R-1:0]   req_valid;
  logic [R-1:0]   req_ready;
  logic [R*N-1:0] req_a;
  logic [R*N-1:0] req_b;
  logic [R-1:0]   req_signed;
  logic           res_valid;
  logic           res_ready;
  logic [2*N-1:0] res;
  logic [1:0]     res_id;

  typedef struct {
    int          id;
    logic [15:0] p;
  } exp_t;

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic        s;
    logic [15:0] exp;
  } vec_t;

  exp_t exp_q[$];
  vec_t tbl[10];
  int   total = 0;
  int   bad = 0;
  int   model_last = R - 1;
  int   last_acc = -1;
  int   consumed = 0;
  int   id2_seen = 0;
  bit   one_shot = 1'b0;

  mul_share_arbiter #(.n(N), .NUM_REQ(R), .ID_W(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_signed (req_signed),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res        (res),
    .res_id     (res_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Plain integer product in the requested interpretation, reduced to 16 bits.
  function automatic logic [15:0] ref_mul(input logic [7:0] a, input logic [7:0] b, input logic s);
    int av;
    int bv;
    av = s ? int'($signed(a)) : int'(a);
    bv = s ? int'($signed(b)) : int'(b);
    return 16'(av * bv);
  endfunction

  // One clock: check grant and result at the current negedge, record transfers, advance.
  task automatic tick();
    int          g;
    bit          s1_free;
    logic [R-1:0] exp_rdy;
    logic [R-1:0] acc;
    exp_t        e;
    #1;
    g = -1;
    for (int k = 1; k <= R; k++) begin
      int c;
      c = (model_last + k) % R;
      if (req_valid[c] && g < 0) g = c;
    end
    s1_free = !(exp_q.size() >= 2 && !res_ready);
    exp_rdy = '0;
    if (g >= 0 && s1_free) exp_rdy[g] = 1'b1;
    check("req_ready", 32'(req_ready), 32'(exp_rdy));
    if (res_valid && res_ready) begin
      consumed++;
      if (res_id == 2'd2) id2_seen++;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL res_spurious: got id %0d res %0h want no result", res_id, res);
      end else begin
        e = exp_q.pop_front();
        check("res", 32'(res), 32'(e.p));
        check("res_id", 32'(res_id), 32'(e.id));
      end
    end
    acc = req_valid & req_ready;
    last_acc = -1;
    for (int i = 0; i < R; i++) begin
      if (acc[i]) begin
        exp_q.push_back('{i, ref_mul(req_a[i*N +: N], req_b[i*N +: N], req_signed[i])});
        model_last = i;
        last_acc = i;
      end
    end
    @(posedge clk);
    @(negedge clk);
    if (one_shot) req_valid = req_valid & ~acc;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    req_valid = '0;
    res_ready = 1'b1;
    exp_q.delete();
    model_last = R - 1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic set_op(input int i, input logic [7:0] a, input logic [7:0] b, input logic s);
    req_a[i*N +: N] = a;
    req_b[i*N +: N] = b;
    req_signed[i] = s;
  endtask

  initial begin
    tbl[0] = '{8'hFF, 8'h02, 1'b1, 16'hFFFE};
    tbl[1] = '{8'hFF, 8'h02, 1'b0, 16'h01FE};
    tbl[2] = '{8'h80, 8'h80, 1'b1, 16'h4000};
    tbl[3] = '{8'h80, 8'h80, 1'b0, 16'h4000};
    tbl[4] = '{8'h80, 8'h7F, 1'b1, 16'hC080};
    tbl[5] = '{8'h80, 8'h7F, 1'b0, 16'h3F80};
    tbl[6] = '{8'hFF, 8'hFF, 1'b1, 16'h0001};
    tbl[7] = '{8'hFF, 8'hFF, 1'b0, 16'hFE01};
    tbl[8] = '{8'h7F, 8'h7F, 1'b1, 16'h3F01};
    tbl[9] = '{8'h00, 8'hA5, 1'b1, 16'h0000};

    // Reset state, with every requester asking.
    rst_n = 1'b0;
    req_valid = '1;
    req_a = '0;
    req_b = '0;
    req_signed = '0;
    res_ready = 1'b1;
    #1;
    check("rst_res_valid", 32'(res_valid), 0);
    check("rst_res", 32'(res), 0);
    check("rst_res_id", 32'(res_id), 0);
    check("rst_req_ready", 32'(req_ready), 0);
    apply_reset();

    // Single ops through requester 0: latency and arithmetic corners.
    one_shot = 1'b1;
    for (int t = 0; t < 10; t++) begin
      set_op(0, tbl[t].a, tbl[t].b, tbl[t].s);
      req_valid[0] = 1'b1;
      tick();
      check("tbl_acc", 32'(last_acc), 0);
      check("tbl_lat1", 32'(res_valid), 0);
      tick();
      check("tbl_vld", 32'(res_valid), 1);
      check("tbl_res", 32'(res), 32'(tbl[t].exp));
      check("tbl_id", 32'(res_id), 0);
      tick();
    end

    // All four continuously valid: strict rotation and one result per cycle.
    apply_reset();
    one_shot = 1'b0;
    for (int i = 0; i < R; i++) set_op(i, 8'(8'h11 * (i + 1)), 8'(8'hF0 - i), i[0]);
    req_valid = '1;
    for (int c = 0; c < 12; c++) begin
      tick();
      check("rr_order", 32'(last_acc), 32'(c % R));
      if (c >= 1) check("full_rate", 32'(res_valid), 1);
    end
    req_valid = '0;
    repeat (3) tick();

    // Backpressure: two ops held, third waits, all three drain in order.
    apply_reset();
    one_shot = 1'b1;
    for (int i = 0; i < 3; i++) set_op(i, 8'($urandom), 8'($urandom), 1'($urandom));
    req_valid = 4'b0111;
    tick();
    tick();
    res_ready = 1'b0;
    consumed = 0;
    repeat (5) begin
      tick();
      check("bp_hold_valid", 32'(res_valid), 1);
      check("bp_no_accept", 32'(last_acc), 32'(-1));
    end
    res_ready = 1'b1;
    repeat (6) tick();
    check("bp_count", 32'(consumed), 3);
    check("bp_empty", 32'(exp_q.size()), 0);

    // Requester 2 withdraws: rotation alternates 1 and 3 and never serves 2.
    apply_reset();
    one_shot = 1'b0;
    id2_seen = 0;
    for (int i = 1; i < R; i++) set_op(i, 8'($urandom), 8'($urandom), 1'($urandom));
    req_valid = 4'b1110;
    tick();
    check("drop_first", 32'(last_acc), 1);
    req_valid[2] = 1'b0;
    for (int c = 0; c < 6; c++) begin
      tick();
      check("drop_order", 32'(last_acc), (c % 2 == 0) ? 32'd3 : 32'd1);
    end
    req_valid = '0;
    repeat (3) tick();
    check("drop_no_id2", 32'(id2_seen), 0);

    // Asynchronous reset with two ops in flight.
    apply_reset();
    one_shot = 1'b1;
    set_op(0, 8'h12, 8'h34, 1'b0);
    set_op(1, 8'h56, 8'h78, 1'b1);
    req_valid = 4'b0011;
    tick();
    tick();
    check("inflight_vld", 32'(res_valid), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_res_valid", 32'(res_valid), 0);
    check("arst_req_ready", 32'(req_ready), 0);
    exp_q.delete();
    model_last = R - 1;
    req_valid = '0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) begin
      tick();
      check("no_stale", 32'(res_valid), 0);
    end
    set_op(3, 8'h03, 8'h05, 1'b0);
    req_valid = 4'b1001;
    tick();
    check("post_rst_grant", 32'(last_acc), 0);
    req_valid = '0;
    repeat (3) tick();

    // Random traffic against the model, with random stalls and withdrawals.
    apply_reset();
    one_shot = 1'b1;
    for (int c = 0; c < 400; c++) begin
      tick();
      for (int i = 0; i < R; i++) begin
        if (!req_valid[i]) begin
          if ($urandom_range(2) == 0) begin
            set_op(i, 8'($urandom), 8'($urandom), 1'($urandom));
            req_valid[i] = 1'b1;
          end
        end else if ($urandom_range(15) == 0) begin
          req_valid[i] = 1'b0;
        end
      end
      res_ready = ($urandom_range(3) != 0);
    end
    req_valid = '0;
    res_ready = 1'b1;
    repeat (4) tick();
    check("rand_drain", 32'(exp_q.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
